// File: rtl/div_ctrl_if.sv
// Request/response handshake between the execute stage and the divide controller.
// The execute stage is the master; div_ctrl is the slave.
interface div_ctrl_if #(
    parameter int unsigned TAG_W = 5
) ();
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag
    );
endinterface

// File: rtl/div_ctrl.sv
// RV32M divide sequencer: sign handling and special cases around a 32-cycle
// unsigned iterative divider, one operation in flight.
module div_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    div_ctrl_if.slave   bus,
    output logic        busy,
    output logic        div_start,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [31:0] div_d,
    input  logic [31:0] div_r,
    input  logic        div_ok
);
    typedef enum logic [1:0] {StIdle, StStart, StBusy, StResp} state_e;

    state_e           state_q, state_d;
    logic             is_rem_q, neg_q_q, neg_r_q;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      div_a_q, div_b_q, data_q;

    logic        req_rdy, accept, sgn, rem, is_zero, is_ovf, special;
    logic [31:0] mag_a, mag_b, special_data, fix_data;
    logic        load_result;

    always_comb begin
        req_rdy = (state_q == StIdle) && !flush;
        accept  = bus.req_valid && req_rdy;
        sgn     = ~bus.req_op[0];
        rem     = bus.req_op[1];
        mag_a   = (sgn && bus.req_a[31]) ? -bus.req_a : bus.req_a;
        mag_b   = (sgn && bus.req_b[31]) ? -bus.req_b : bus.req_b;
        is_zero = (bus.req_b == 32'h0);
        is_ovf  = sgn && (bus.req_a == 32'h8000_0000) && (bus.req_b == 32'hFFFF_FFFF);
        special = is_zero || is_ovf;
        // Divide-by-zero takes priority; remainder is the raw dividend.
        if (is_zero) begin
            special_data = rem ? bus.req_a : 32'hFFFF_FFFF;
        end else begin
            special_data = rem ? 32'h0 : 32'h8000_0000;
        end
        if (is_rem_q) begin
            fix_data = neg_r_q ? -div_r : div_r;
        end else begin
            fix_data = neg_q_q ? -div_d : div_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        load_result = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = special ? StResp : StStart;
                end
            end
            StStart: state_d = StBusy;
            StBusy: begin
                if (div_ok) begin
                    load_result = 1'b1;
                    state_d     = StResp;
                end
            end
            StResp: begin
                if (bus.resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (flush) begin
            state_d     = StIdle;
            load_result = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            tag_q    <= '0;
            div_a_q  <= 32'h0;
            div_b_q  <= 32'h0;
            data_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                is_rem_q <= rem;
                neg_q_q  <= sgn && (bus.req_a[31] ^ bus.req_b[31]);
                neg_r_q  <= sgn && bus.req_a[31];
                tag_q    <= bus.req_tag;
                // Special cases bypass the divider, so its operands stay untouched.
                if (special) begin
                    data_q <= special_data;
                end else begin
                    div_a_q <= mag_a;
                    div_b_q <= mag_b;
                end
            end
            if (load_result) begin
                data_q <= fix_data;
            end
        end
    end

    assign bus.req_ready  = req_rdy;
    assign bus.resp_valid = (state_q == StResp);
    assign bus.resp_data  = data_q;
    assign bus.resp_tag   = tag_q;
    assign busy           = (state_q != StIdle);
    assign div_start      = (state_q == StStart);
    assign div_a          = div_a_q;
    assign div_b          = div_b_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: behavioural 32-cycle divider, RV32M reference
// results from plain signed/unsigned arithmetic, directed plus random operations.
module tb_div_ctrl;
    localparam int unsigned TAG_W = 5;
    localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        flush = 1'b0;
    logic        busy, div_start, div_ok;
    logic [31:0] div_a, div_b, div_d, div_r;
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    div_ctrl_if #(.TAG_W(TAG_W)) bus_if ();

    div_ctrl #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .bus       (bus_if),
        .busy      (busy),
        .div_start (div_start),
        .div_a     (div_a),
        .div_b     (div_b),
        .div_d     (div_d),
        .div_r     (div_r),
        .div_ok    (div_ok)
    );

    // Iterative divider stand-in: low for 32 cycles after a start, start restarts it.
    logic [5:0]  dv_cnt = 6'd0;
    logic [31:0] dv_q = 32'h0, dv_r = 32'h0;
    always @(posedge clk) begin
        if (div_start) begin
            dv_cnt <= 6'd32;
            dv_q   <= (div_b == 0) ? 32'hFFFF_FFFF : div_a / div_b;
            dv_r   <= (div_b == 0) ? div_a : div_a % div_b;
        end else if (dv_cnt != 0) begin
            dv_cnt <= dv_cnt - 6'd1;
        end
    end
    assign div_ok = (dv_cnt == 0);
    assign div_d  = dv_q;
    assign div_r  = dv_r;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : 32'h8000_0000;
            return 32'(op[1] ? sa % sb : sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic logic [31:0] mag(input logic sgn, input logic [31:0] x);
        return (sgn && x[31]) ? 32'(0 - x) : x;
    endfunction

    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tag);
        int w = 0;
        while (!bus_if.req_ready && w < 50) begin
            step();
            w++;
        end
        check_eq("req_ready_before_accept", 64'(bus_if.req_ready), 64'd1);
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = op;
        bus_if.req_a     = a;
        bus_if.req_b     = b;
        bus_if.req_tag   = tag;
        step();
        bus_if.req_valid = 1'b0;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, input int stall);
        logic        sgn;
        bit          special;
        int          lat = 1;
        int          starts = 0;
        int          start_lat = 0;
        logic [31:0] exp_data;
        sgn      = ~op[0];
        special  = (b == 0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        exp_data = ref_result(op, a, b);
        bus_if.resp_ready = 1'b0;
        send(op, a, b, tag);
        while (!bus_if.resp_valid && lat < 100) begin
            if (div_start) begin
                starts++;
                start_lat = lat;
                check_eq("div_a", 64'(div_a), 64'(mag(sgn, a)));
                check_eq("div_b", 64'(div_b), 64'(mag(sgn, b)));
            end
            step();
            lat++;
        end
        check_eq("latency", 64'(lat), special ? 64'd1 : 64'd35);
        check_eq("start_count", 64'(starts), special ? 64'd0 : 64'd1);
        if (!special) check_eq("start_latency", 64'(start_lat), 64'd1);
        check_eq("resp_data", 64'(bus_if.resp_data), 64'(exp_data));
        check_eq("resp_tag", 64'(bus_if.resp_tag), 64'(tag));
        for (int i = 0; i < stall; i++) begin
            step();
            check_eq("hold_valid", 64'(bus_if.resp_valid), 64'd1);
            check_eq("hold_data", 64'(bus_if.resp_data), 64'(exp_data));
            check_eq("hold_tag", 64'(bus_if.resp_tag), 64'(tag));
            check_eq("hold_req_ready", 64'(bus_if.req_ready), 64'd0);
        end
        bus_if.resp_ready = 1'b1;
        step();
        bus_if.resp_ready = 1'b0;
        check_eq("resp_valid_after_hs", 64'(bus_if.resp_valid), 64'd0);
        check_eq("req_ready_after_hs", 64'(bus_if.req_ready), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_resp_valid"}, 64'(bus_if.resp_valid), 64'd0);
        check_eq({tag, "_resp_data"}, 64'(bus_if.resp_data), 64'd0);
        check_eq({tag, "_resp_tag"}, 64'(bus_if.resp_tag), 64'd0);
        check_eq({tag, "_div_start"}, 64'(div_start), 64'd0);
        check_eq({tag, "_div_a"}, 64'(div_a), 64'd0);
        check_eq({tag, "_div_b"}, 64'(div_b), 64'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;
        int          mode;
        bus_if.req_valid  = 1'b0;
        bus_if.req_op     = 2'b00;
        bus_if.req_a      = 32'h0;
        bus_if.req_b      = 32'h0;
        bus_if.req_tag    = '0;
        bus_if.resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        step();
        check_eq("req_ready_post_reset", 64'(bus_if.req_ready), 64'd1);

        // Directed operations
        do_op(OP_DIVU, 32'd100, 32'd7, 5'h15, 0);
        do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'h03, 0);
        do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'h04, 0);
        do_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 5'h05, 0);
        do_op(OP_DIV, 32'd5, 32'd0, 5'h06, 0);
        do_op(OP_REMU, 32'd5, 32'd0, 5'h07, 0);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'h08, 0);
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'h09, 0);
        do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'h0A, 0);
        do_op(OP_DIVU, 32'd1000, 32'd10, 5'h1B, 10);

        // Flush during BUSY, with a request presented in the flush cycle
        send(OP_DIVU, 32'd1000, 32'd3, 5'h11);
        repeat (19) step();
        check_eq("busy_before_flush", 64'(busy), 64'd1);
        flush = 1'b1;
        bus_if.req_valid = 1'b1;
        bus_if.req_op    = OP_DIVU;
        bus_if.req_a     = 32'd50;
        bus_if.req_b     = 32'd5;
        #1;
        check_eq("req_ready_in_flush", 64'(bus_if.req_ready), 64'd0);
        step();
        flush = 1'b0;
        bus_if.req_valid = 1'b0;
        check_eq("busy_after_flush", 64'(busy), 64'd0);
        check_eq("resp_valid_after_flush", 64'(bus_if.resp_valid), 64'd0);
        do_op(OP_DIVU, 32'd9, 32'd2, 5'h12, 0);

        // Flush while a response is pending discards it
        send(OP_DIV, 32'd5, 32'd0, 5'h13);
        check_eq("resp_pending", 64'(bus_if.resp_valid), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("resp_discarded", 64'(bus_if.resp_valid), 64'd0);
        check_eq("busy_discarded", 64'(busy), 64'd0);

        // Asynchronous reset mid-operation
        send(OP_REMU, 32'd100, 32'd7, 5'h14);
        repeat (10) step();
        #3 reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step();
        do_op(OP_REMU, 32'd9, 32'd2, 5'h16, 0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            mode = $urandom_range(0, 9);
            a    = $urandom;
            b    = $urandom;
            if (mode == 0) b = 32'h0;
            else if (mode == 1) begin
                a = 32'h8000_0000;
                b = 32'hFFFF_FFFF;
            end else if (mode < 5) begin
                a = $urandom_range(0, 300);
                b = $urandom_range(1, 20);
                if ($urandom_range(0, 1) == 1) a = 32'(0 - a);
                if ($urandom_range(0, 1) == 1) b = 32'(0 - b);
            end
            do_op(op, a, b, 5'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
